stroke_rasterizer: RTL

Converts the stream of brush coordinates decoded from the MCU SPI link into a per-pixel write stream for the pixel store. It sits between the SPI decoder and the pixel store and interpolates a Bresenham line from the previous point to each new point, so fast pen motion leaves continuous strokes instead of isolated dots. It emits one pixel write per cycle with no backpressure; the pixel store always accepts writes.

---
 rtl/draw_pkg.sv | 17 +
 rtl/brush_footprint.sv | 50 +++++
 rtl/stroke_rasterizer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the stroke rasterizer.
// Footprint offsets are only consumed when STROKE_WIDE_BRUSH_EN is defined.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    FOOT = 2'd2
  } stroke_state_t;

  localparam int COORD_W_DEFAULT = 8;

  // Bit i is the x / y offset of footprint write i: (0,0) (1,0) (0,1) (1,1)
  localparam logic [3:0] FOOT_OFF_X = 4'b1010;
  localparam logic [3:0] FOOT_OFF_Y = 4'b1100;

endpackage

// File: rtl/brush_footprint.sv
// 2x2 brush expansion: sequences four saturated writes around each line pixel.
// Only compiled when STROKE_WIDE_BRUSH_EN is defined.
`ifdef STROKE_WIDE_BRUSH_EN
module brush_footprint
  import draw_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               active,
  input  logic [COORD_W-1:0] base_x,
  input  logic [COORD_W-1:0] base_y,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic               step
);

  logic [1:0] cnt;
  logic [1:0] cnt_nx;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v,
                                                 input logic inc);
    return (inc && (v != '1)) ? v + COORD_W'(1) : v;
  endfunction

  always_comb begin
    cnt_nx = 2'd0;
    if (load)        cnt_nx = 2'd0;
    else if (active) cnt_nx = cnt + 2'd1;
  end

  // base_x/base_y are the next-cycle pixel, so the write address lands registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= 2'd0;
      wr_x <= '0;
      wr_y <= '0;
    end else begin
      cnt  <= cnt_nx;
      wr_x <= sat_inc(base_x, FOOT_OFF_X[cnt_nx]);
      wr_y <= sat_inc(base_y, FOOT_OFF_Y[cnt_nx]);
    end
  end

  assign step = (cnt == 2'd3);

endmodule
`endif

// File: rtl/stroke_rasterizer.sv
// Bresenham line engine turning brush points into a one-pixel-per-cycle write stream.
// Define STROKE_WIDE_BRUSH_EN to expand every pixel into a 2x2 footprint.
module stroke_rasterizer
  import draw_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  input  logic               pt_start,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic               busy
);

  // 3 guard bits keep 2*err in range for any canvas-spanning line
  localparam int ERR_W = COORD_W + 3;
  localparam logic signed [ERR_W-1:0] ERR_ZERO = '0;

  stroke_state_t state, state_nx;

  logic               has_prev;
  logic [COORD_W-1:0] px, py, ex, ey, cur_x, cur_y;
  logic signed [ERR_W-1:0] dx, dy, err;
  logic               sx_neg, sy_neg;

  logic               xfer, at_end, pix_done, adv, done;
  logic [COORD_W-1:0] x0, y0, nx, ny;
  logic signed [ERR_W-1:0] diff_x, diff_y, dx_init, dy_init, e2, err_nx;
  logic               step_x, step_y;

  function automatic logic signed [ERR_W-1:0] abs_s(input logic signed [ERR_W-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                    input logic neg);
    return neg ? c - COORD_W'(1) : c + COORD_W'(1);
  endfunction

  assign xfer   = pt_valid && pt_ready;
  assign at_end = (cur_x == ex) && (cur_y == ey);
  assign adv    = pix_done && !at_end;
  assign done   = pix_done && at_end;

  // Setup for the incoming point: a fresh stroke collapses to a single pixel
  always_comb begin
    x0      = (pt_start || !has_prev) ? pt_x : px;
    y0      = (pt_start || !has_prev) ? pt_y : py;
    diff_x  = $signed({{(ERR_W-COORD_W){1'b0}}, pt_x}) - $signed({{(ERR_W-COORD_W){1'b0}}, x0});
    diff_y  = $signed({{(ERR_W-COORD_W){1'b0}}, pt_y}) - $signed({{(ERR_W-COORD_W){1'b0}}, y0});
    dx_init = abs_s(diff_x);
    dy_init = -abs_s(diff_y);
  end

  always_comb begin
    e2     = err <<< 1;
    step_x = (e2 >= dy);
    step_y = (e2 <= dx);
    err_nx = err + (step_x ? dy : ERR_ZERO) + (step_y ? dx : ERR_ZERO);
    nx     = step_x ? step_coord(cur_x, sx_neg) : cur_x;
    ny     = step_y ? step_coord(cur_y, sy_neg) : cur_y;
  end

`ifdef STROKE_WIDE_BRUSH_EN
  logic               step;
  logic [COORD_W-1:0] base_x_nx, base_y_nx;

  assign pix_done  = (state == FOOT) && step;
  assign base_x_nx = xfer ? x0 : (adv ? nx : cur_x);
  assign base_y_nx = xfer ? y0 : (adv ? ny : cur_y);

  brush_footprint #(
    .COORD_W(COORD_W)
  ) u_footprint (
    .clk    (clk),
    .reset  (reset),
    .load   (xfer),
    .active (state != IDLE),
    .base_x (base_x_nx),
    .base_y (base_y_nx),
    .wr_x   (wr_x),
    .wr_y   (wr_y),
    .step   (step)
  );
`else
  assign pix_done = (state == LINE);
  assign wr_x     = cur_x;
  assign wr_y     = cur_y;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (xfer) state_nx = LINE;
`ifdef STROKE_WIDE_BRUSH_EN
      LINE: state_nx = FOOT;
      FOOT: if (step) state_nx = at_end ? IDLE : LINE;
`else
      LINE: if (at_end) state_nx = IDLE;
      FOOT: state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pt_ready = (state == IDLE);
    busy     = (state != IDLE);
    wr_en    = (state != IDLE);
  end

  // Control and current position: reset aborts the line and forgets the stroke
  always_ff @(posedge clk) begin
    if (!reset) begin
      has_prev <= 1'b0;
      px       <= '0;
      py       <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
    end else begin
      if (xfer) begin
        cur_x <= x0;
        cur_y <= y0;
      end else if (adv) begin
        cur_x <= nx;
        cur_y <= ny;
      end
      if (done) begin
        px       <= ex;
        py       <= ey;
        has_prev <= 1'b1;
      end
    end
  end

  // Line parameters are only meaningful while busy, so they carry no reset
  always_ff @(posedge clk) begin
    if (xfer) begin
      ex     <= pt_x;
      ey     <= pt_y;
      dx     <= dx_init;
      dy     <= dy_init;
      err    <= dx_init + dy_init;
      sx_neg <= (diff_x < 0);
      sy_neg <= (diff_y < 0);
    end else if (adv) begin
      err <= err_nx;
    end
  end

endmodule
